seq_serializer: RTL and testbench
=================================

// Module: seq_serializer
// PURPOSE
//   Parallel-to-serial bit source. Feeds the sequence detector's 1-bit din input.
//   Accepts WIDTH-bit words over a valid/ready write port and buffers them in a small FIFO.
//   Shifts each word out one bit per clk on ser_out, which connects directly to seq_det.din.
//   Consecutive words stream back-to-back, so patterns can span word boundaries.
// PARAMETERS
//   WIDTH      8  bits per word (>=2)
//   DEPTH      2  FIFO entries (power of 2, >=2)
//   MSB_FIRST  1  1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
//   IDLE_BIT   0  level driven on ser_out when no bit is being sent
// PORTS
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-high; clears all state
//   wr_valid   in   1      wr_data is valid this cycle
//   wr_ready   out  1      FIFO can accept a word; equals !full
//   wr_data    in   WIDTH  word to serialize
//   ser_out    out  1      registered serial bit; drives seq_det.din
//   ser_valid  out  1      high while ser_out carries a frame bit
//   word_done  out  1      one-cycle pulse on the last bit of a frame
//   busy       out  1      high when state != IDLE or FIFO non-empty
// BEHAVIOUR
//   - Reset values: ser_out=IDLE_BIT, ser_valid=0, word_done=0, busy=0.
//     FIFO pointers and count = 0; bit counter = 0; state = IDLE.
//     wr_ready=0 while reset is asserted, and 1 on the first cycle after release.
//   - Write: the word is stored at the clk edge where wr_valid && wr_ready.
//     wr_ready depends only on registered count; there is no same-cycle pass-through.
//     When full, wr_valid is ignored and no data is lost or overwritten.
//   - FSM states: IDLE, SHIFT (plus PARITY when enabled).
//   - IDLE: if FIFO non-empty at an edge, pop the head into the shift register.
//     On that same edge, drive the first bit on ser_out, set ser_valid=1, go to SHIFT.
//   - Latency: a word written at edge N into an empty FIFO while IDLE shows bit 0 of
//     the frame after edge N+1.
//   - SHIFT: each bit is held exactly one cycle. The bit counter runs 0..WIDTH-1.
//     On the last data bit, word_done=1 (when parity is disabled).
//   - End of frame with FIFO non-empty: pop the next word at the same edge.
//     Its first bit follows with no gap.
//   - End of frame with FIFO empty: return to IDLE, ser_out=IDLE_BIT, ser_valid=0.
//   - Simultaneous push and pop: both take effect and count is unchanged.
//     A push into an empty FIFO is not visible to the pop until the next edge.
//   - Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
//   - Reset mid-frame: the partial word and all buffered words are discarded.
//     Outputs go to reset values immediately (async).
// CONFIGURATION
//   SER_PARITY_EN defined:
//     - After the last data bit, enter PARITY for 1 cycle.
//     - ser_out = ^word (even parity), ser_valid=1, word_done=1 in that cycle.
//     - Data bits carry word_done=0. Frame length = WIDTH+1.
//     - Back-to-back chaining happens from PARITY instead of SHIFT.
//   SER_PARITY_EN undefined:
//     - PARITY state and its logic are absent. Frame length = WIDTH.
// TESTING
//   1. reset, write 8'hA5 (MSB_FIRST=1):
//      ser_out=1,0,1,0,0,1,0,1 on 8 consecutive cycles starting 1 cycle after accept.
//      word_done on the 8th bit, then ser_out=0 and ser_valid=0.
//   2. Write 8'hFF then 8'h00 on consecutive cycles:
//      16 contiguous ser_valid cycles (8 ones then 8 zeros), no idle gap.
//      word_done pulses twice.
//   3. DEPTH=2, write 3 words on 3 consecutive cycles:
//      word 1 is popped, words 2 and 3 are buffered, and wr_ready=0.
//      wr_ready returns to 1 on the cycle after word 2 is popped.
//   4. Assert reset after 3 bits of 8'hF0:
//      ser_out=IDLE_BIT, ser_valid=0, busy=0 immediately.
//      A new write of 8'h0F then streams 0,0,0,0,1,1,1,1.
//   5. MSB_FIRST=0, write 8'h01: ser_out=1 then seven 0s.
//   6. With SER_PARITY_EN, write 8'h07:
//      9-bit frame whose 9th bit is 1; word_done asserts only on the 9th bit.
//      Without SER_PARITY_EN: 8-bit frame, word_done on the 8th bit.

Source files
------------

// File: rtl/seq_serializer.sv
// seq_serializer: parallel-to-serial bit source for the sequence detector.
// Words enter through a valid/ready write port into a small FIFO and are
// shifted out one bit per clock on ser_out, back-to-back across words.
// Optional feature macro: SER_PARITY_EN appends an even-parity bit to each frame.
module seq_serializer #(
    parameter int   WIDTH     = 8,
    parameter int   DEPTH     = 2,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(WIDTH - 2);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_t;
`else
    typedef enum logic [0:0] {S_IDLE, S_SHIFT} state_t;
`endif

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               ser_out_q, ser_out_d;
    logic               ser_valid_q, ser_valid_d;
    logic               word_done_q, word_done_d;
    logic               wr_ready_q, wr_ready_d;
`ifdef SER_PARITY_EN
    logic               parity_q, parity_d;
`endif

    logic               push;
    logic               pop;
    logic               load;
    logic               frame_end;
    logic [WIDTH-1:0]   head;

    // Next-state logic: FIFO bookkeeping, frame sequencing and output bits.
    always_comb begin
        push        = wr_valid && wr_ready_q;
        head        = mem_q[rd_ptr_q];
        pop         = 1'b0;
        load        = 1'b0;
        frame_end   = 1'b0;
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        ser_out_d   = ser_out_q;
        ser_valid_d = ser_valid_q;
        word_done_d = 1'b0;
`ifdef SER_PARITY_EN
        parity_d    = parity_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    load = 1'b1;
                end
            end
            S_SHIFT: begin
                if (bit_cnt_q == LAST_BIT) begin
`ifdef SER_PARITY_EN
                    state_d     = S_PARITY;
                    ser_out_d   = parity_q;
                    ser_valid_d = 1'b1;
                    word_done_d = 1'b1;
`else
                    frame_end   = 1'b1;
`endif
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (MSB_FIRST) begin
                        ser_out_d = shift_q[WIDTH-1];
                        shift_d   = {shift_q[WIDTH-2:0], 1'b0};
                    end else begin
                        ser_out_d = shift_q[0];
                        shift_d   = {1'b0, shift_q[WIDTH-1:1]};
                    end
`ifndef SER_PARITY_EN
                    word_done_d = (bit_cnt_q == PRE_LAST);
`endif
                end
            end
`ifdef SER_PARITY_EN
            S_PARITY: begin
                frame_end = 1'b1;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (frame_end) begin
            if (count_q != '0) begin
                load = 1'b1;
            end else begin
                state_d     = S_IDLE;
                ser_out_d   = IDLE_BIT;
                ser_valid_d = 1'b0;
                bit_cnt_d   = '0;
            end
        end

        if (load) begin
            pop         = 1'b1;
            state_d     = S_SHIFT;
            bit_cnt_d   = '0;
            ser_valid_d = 1'b1;
            word_done_d = 1'b0;
            if (MSB_FIRST) begin
                ser_out_d = head[WIDTH-1];
                shift_d   = {head[WIDTH-2:0], 1'b0};
            end else begin
                ser_out_d = head[0];
                shift_d   = {1'b0, head[WIDTH-1:1]};
            end
`ifdef SER_PARITY_EN
            parity_d = ^head;
`endif
        end

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
        wr_ready_d = (count_d != FULL_CNT);
    end

    // FIFO storage holds data only; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // State, pointer and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            ser_out_q   <= IDLE_BIT;
            ser_valid_q <= 1'b0;
            word_done_q <= 1'b0;
            wr_ready_q  <= 1'b0;
`ifdef SER_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            word_done_q <= word_done_d;
            wr_ready_q  <= wr_ready_d;
`ifdef SER_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign wr_ready  = wr_ready_q;
    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign word_done = word_done_q;
    assign busy      = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_seq_serializer.sv
// Testbench for seq_serializer: directed scenarios with hand-derived bit streams.
// Follows SER_PARITY_EN the same way the design does to pick the frame length.
module tb_seq_serializer;

`ifdef SER_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = '0;
    logic       wr_ready, ser_out, ser_valid, word_done, busy;
    logic       wr_valid_l = 1'b0;
    logic [7:0] wr_data_l = '0;
    logic       wr_ready_l, ser_out_l, ser_valid_l, word_done_l, busy_l;

    int checks = 0;
    int failures = 0;

    seq_serializer #(.WIDTH(8), .DEPTH(2), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .ser_out(ser_out), .ser_valid(ser_valid),
        .word_done(word_done), .busy(busy)
    );

    seq_serializer #(.WIDTH(8), .DEPTH(2), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .wr_valid(wr_valid_l), .wr_ready(wr_ready_l),
        .wr_data(wr_data_l), .ser_out(ser_out_l), .ser_valid(ser_valid_l),
        .word_done(word_done_l), .busy(busy_l)
    );

    always #5 clk = ~clk;

    // Expected bit i of a frame carrying word w; index 8 is the even-parity bit.
    function automatic logic exp_bit(input logic [7:0] w, input int i, input bit msb);
        if (i >= 8) return ^w;
        return msb ? w[7 - i] : w[i];
    endfunction

    // Single-cycle write on the main instance; returns at the negedge after the accept edge.
    task automatic write_word(input logic [7:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (ser_out !== 1'b0) begin failures++; $display("[TB] FAIL rst_ser_out got=%b exp=0", ser_out); end
        checks++; if (ser_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_ser_valid got=%b exp=0", ser_valid); end
        checks++; if (word_done !== 1'b0) begin failures++; $display("[TB] FAIL rst_word_done got=%b exp=0", word_done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_wr_ready got=%b exp=0", wr_ready); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("[TB] FAIL post_rst_wr_ready got=%b exp=1", wr_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL post_rst_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single_word();
        write_word(8'hA5);
        checks++; if (ser_valid !== 1'b0) begin failures++; $display("[TB] FAIL a5_latency_valid got=%b exp=0", ser_valid); end
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL a5_busy_queued got=%b exp=1", busy); end
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            checks++; if (ser_out !== exp_bit(8'hA5, i, 1'b1)) begin failures++; $display("[TB] FAIL a5_bit%0d got=%b exp=%b", i, ser_out, exp_bit(8'hA5, i, 1'b1)); end
            checks++; if (ser_valid !== 1'b1) begin failures++; $display("[TB] FAIL a5_valid%0d got=%b exp=1", i, ser_valid); end
            checks++; if (word_done !== (i == FL - 1)) begin failures++; $display("[TB] FAIL a5_done%0d got=%b exp=%b", i, word_done, (i == FL - 1)); end
        end
        @(negedge clk);
        checks++; if (ser_valid !== 1'b0) begin failures++; $display("[TB] FAIL a5_end_valid got=%b exp=0", ser_valid); end
        checks++; if (ser_out !== 1'b0) begin failures++; $display("[TB] FAIL a5_end_idle_bit got=%b exp=0", ser_out); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL a5_end_busy got=%b exp=0", busy); end
        checks++; if (word_done !== 1'b0) begin failures++; $display("[TB] FAIL a5_end_done got=%b exp=0", word_done); end
    endtask

    task automatic test_back_to_back();
        int done_cnt = 0;
        logic [7:0] w;
        wr_valid = 1'b1;
        wr_data  = 8'hFF;
        @(negedge clk);
        wr_data  = 8'h00;
        @(negedge clk);
        wr_valid = 1'b0;
        for (int i = 0; i < 2 * FL; i++) begin
            if (i > 0) @(negedge clk);
            w = (i < FL) ? 8'hFF : 8'h00;
            done_cnt += int'(word_done);
            checks++; if (ser_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_valid%0d got=%b exp=1", i, ser_valid); end
            checks++; if (ser_out !== exp_bit(w, i % FL, 1'b1)) begin failures++; $display("[TB] FAIL b2b_bit%0d got=%b exp=%b", i, ser_out, exp_bit(w, i % FL, 1'b1)); end
            checks++; if (word_done !== ((i % FL) == FL - 1)) begin failures++; $display("[TB] FAIL b2b_done%0d got=%b exp=%b", i, word_done, ((i % FL) == FL - 1)); end
        end
        @(negedge clk);
        checks++; if (ser_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_end_valid got=%b exp=0", ser_valid); end
        checks++; if (done_cnt != 2) begin failures++; $display("[TB] FAIL b2b_done_count got=%0d exp=2", done_cnt); end
    endtask

    task automatic test_fifo_full();
        logic [7:0] words [3];
        logic       exp_ready;
        int         j;
        words[0] = 8'h81;
        words[1] = 8'h3C;
        words[2] = 8'hC3;
        for (int k = 1; k <= 2 + 3 * FL; k++) begin
            if (k <= 3) begin
                wr_valid = 1'b1;
                wr_data  = words[k - 1];
            end else if (k <= 6) begin
                wr_valid = 1'b1;
                wr_data  = 8'hEE;
            end else begin
                wr_valid = 1'b0;
            end
            @(negedge clk);
            exp_ready = !(k >= 3 && k < 2 + FL);
            checks++; if (wr_ready !== exp_ready) begin failures++; $display("[TB] FAIL full_ready_k%0d got=%b exp=%b", k, wr_ready, exp_ready); end
            if (k >= 2 && k < 2 + 3 * FL) begin
                j = k - 2;
                checks++; if (ser_valid !== 1'b1) begin failures++; $display("[TB] FAIL full_valid_k%0d got=%b exp=1", k, ser_valid); end
                checks++; if (ser_out !== exp_bit(words[j / FL], j % FL, 1'b1)) begin failures++; $display("[TB] FAIL full_bit_k%0d got=%b exp=%b", k, ser_out, exp_bit(words[j / FL], j % FL, 1'b1)); end
            end else begin
                checks++; if (ser_valid !== 1'b0) begin failures++; $display("[TB] FAIL full_idle_k%0d got=%b exp=0", k, ser_valid); end
            end
        end
    endtask

    task automatic test_reset_midframe();
        write_word(8'hF0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (ser_out !== 1'b1) begin failures++; $display("[TB] FAIL f0_bit%0d got=%b exp=1", i, ser_out); end
        end
        reset = 1'b1;
        #1;
        checks++; if (ser_out !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_ser_out got=%b exp=0", ser_out); end
        checks++; if (ser_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_valid got=%b exp=0", ser_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_busy got=%b exp=0", busy); end
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_ready got=%b exp=0", wr_ready); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_flushed_busy got=%b exp=0", busy); end
        write_word(8'h0F);
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            checks++; if (ser_out !== exp_bit(8'h0F, i, 1'b1)) begin failures++; $display("[TB] FAIL 0f_bit%0d got=%b exp=%b", i, ser_out, exp_bit(8'h0F, i, 1'b1)); end
            checks++; if (ser_valid !== 1'b1) begin failures++; $display("[TB] FAIL 0f_valid%0d got=%b exp=1", i, ser_valid); end
        end
        @(negedge clk);
        checks++; if (ser_valid !== 1'b0) begin failures++; $display("[TB] FAIL 0f_end_valid got=%b exp=0", ser_valid); end
    endtask

    task automatic test_lsb_first();
        checks++; if (wr_ready_l !== 1'b1) begin failures++; $display("[TB] FAIL lsb_ready got=%b exp=1", wr_ready_l); end
        wr_valid_l = 1'b1;
        wr_data_l  = 8'h01;
        @(negedge clk);
        wr_valid_l = 1'b0;
        checks++; if (ser_valid_l !== 1'b0) begin failures++; $display("[TB] FAIL lsb_latency_valid got=%b exp=0", ser_valid_l); end
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            checks++; if (ser_out_l !== exp_bit(8'h01, i, 1'b0)) begin failures++; $display("[TB] FAIL lsb_bit%0d got=%b exp=%b", i, ser_out_l, exp_bit(8'h01, i, 1'b0)); end
            checks++; if (word_done_l !== (i == FL - 1)) begin failures++; $display("[TB] FAIL lsb_done%0d got=%b exp=%b", i, word_done_l, (i == FL - 1)); end
        end
        @(negedge clk);
        checks++; if (ser_valid_l !== 1'b0) begin failures++; $display("[TB] FAIL lsb_end_valid got=%b exp=0", ser_valid_l); end
        checks++; if (busy_l !== 1'b0) begin failures++; $display("[TB] FAIL lsb_end_busy got=%b exp=0", busy_l); end
    endtask

    task automatic test_parity();
        write_word(8'h07);
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            checks++; if (ser_out !== exp_bit(8'h07, i, 1'b1)) begin failures++; $display("[TB] FAIL p07_bit%0d got=%b exp=%b", i, ser_out, exp_bit(8'h07, i, 1'b1)); end
            checks++; if (word_done !== (i == FL - 1)) begin failures++; $display("[TB] FAIL p07_done%0d got=%b exp=%b", i, word_done, (i == FL - 1)); end
        end
        @(negedge clk);
        checks++; if (ser_valid !== 1'b0) begin failures++; $display("[TB] FAIL p07_end_valid got=%b exp=0", ser_valid); end
    endtask

    // Scenario sequence followed by the single summary line.
    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_fifo_full();
        test_reset_midframe();
        test_lsb_first();
        test_parity();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Time bound so a stuck run still terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
